// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator with per-channel enable, periodic/one-shot
// mode and shadowed compare values. Define PRESCALE_EN to add a shared clock prescaler.
module multi_tick_gen #(
    parameter int                 NBITS     = 8,
    parameter int                 NCH       = 4,
    parameter logic [NBITS-1:0]   RESET_CMP = {NBITS{1'b1}},
    parameter int                 PRESC_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        en,
    input  logic [NCH-1:0]        mode,
    input  logic [NCH-1:0]        start,
    input  logic [NCH-1:0]        load,
    input  logic [NCH*NBITS-1:0]  compare_value,
    output logic [NCH-1:0]        tick,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        pending,
    output logic [NCH*NBITS-1:0]  count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic strobe;

`ifdef PRESCALE_EN
    localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] presc_q;

    // Free-running and shared by all channels, so every channel sees the same strobe phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign strobe = (presc_q == PRESC_LAST);
`else
    // Without the prescaler every cycle is a counting cycle; PRESC_DIV has no effect.
    localparam bit PRESC_UNUSED = (PRESC_DIV != 0);
    assign strobe = PRESC_UNUSED | 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t           state_q, state_d;
            logic [NBITS-1:0] cnt_q, cnt_d;
            logic [NBITS-1:0] prd_q, prd_d;
            logic [NBITS-1:0] shadow_q, shadow_d;
            logic             pending_q, pending_d;
            logic             mode_q, mode_d;
            logic             tick_q, tick_d;
            logic [NBITS-1:0] slice;
            logic             wrap;

            assign slice = compare_value[gi*NBITS +: NBITS];
            // Abort (en low) takes priority over the wrap.
            assign wrap  = (state_q == ST_RUN) && en[gi] && strobe && (cnt_q == prd_q);

            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                prd_d     = prd_q;
                shadow_d  = shadow_q;
                pending_d = pending_q;
                mode_d    = mode_q;
                tick_d    = 1'b0;

                if (state_q == ST_IDLE) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        prd_d     = shadow_q;
                        pending_d = 1'b0;
                    end
                    if (en[gi] && (!mode[gi] || start[gi])) begin
                        state_d = ST_RUN;
                        mode_d  = mode[gi];
                    end
                end else if (!en[gi]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (pending_q) begin
                        prd_d     = shadow_q;
                        pending_d = 1'b0;
                    end
                    if (mode_q) begin
                        state_d = ST_IDLE;
                    end
                end else if (strobe) begin
                    cnt_d = cnt_q + 1'b1;
                end

                // A load coinciding with the wrap bypasses the shadow and takes effect at once.
                if (load[gi]) begin
                    shadow_d = slice;
                    if (wrap) begin
                        prd_d     = slice;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    prd_q     <= RESET_CMP;
                    shadow_q  <= RESET_CMP;
                    pending_q <= 1'b0;
                    mode_q    <= 1'b0;
                    tick_q    <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    prd_q     <= prd_d;
                    shadow_q  <= shadow_d;
                    pending_q <= pending_d;
                    mode_q    <= mode_d;
                    tick_q    <= tick_d;
                end
            end

            assign tick[gi]                   = tick_q;
            assign busy[gi]                   = (state_q == ST_RUN);
            assign pending[gi]                = pending_q;
            assign count[gi*NBITS +: NBITS]   = cnt_q;
        end
    endgenerate

endmodule

// File: doc/multi_tick_gen.md
Name: multi_tick_gen

Overview:
- Multi-channel programmable tick generator; successor to the single-channel count/compare divider.
- Each of NCH channels counts 0..prd and emits a one-cycle registered tick on wrap.
- Adds per-channel enable, periodic/one-shot mode, and shadowed compare values applied glitch-free at wrap.
- Drives display digit-scan, blink and debounce timing for the 7-segment subsystem.

Parameters:
- NBITS, 8, counter and compare width per channel.
- NCH, 4, number of independent channels.
- RESET_CMP, {NBITS{1'b1}}, reset value of active and shadow compare registers.
- PRESC_DIV, 16, clock divide ratio, used only when PRESCALE_EN is defined (must be >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en  in  NCH  per-channel enable, level.
- mode  in  NCH  0 = periodic, 1 = one-shot; sampled only on IDLE exit.
- start  in  NCH  one-shot arm pulse.
- load  in  NCH  capture compare_value slice into the shadow register.
- compare_value  in  NCH*NBITS  channel i at bits [i*NBITS +: NBITS].
- tick  out  NCH  one-cycle registered wrap pulse.
- busy  out  NCH  channel in RUN.
- pending  out  NCH  shadow loaded, not yet applied.
- count  out  NCH*NBITS  current counter value per channel.

Behaviour:
- Reset (async, rst=0):
  - tick, busy, pending and count all 0.
  - Every channel in IDLE.
  - prd = shadow = RESET_CMP.
  - mode_q = 0.
- Per-channel FSM with states IDLE and RUN.
- IDLE:
  - cnt = 0.
  - If mode=0 and en=1: go to RUN and latch mode_q=0.
  - If mode=1, en=1 and start=1: go to RUN and latch mode_q=1.
  - If pending=1: prd <= shadow and pending <= 0, every cycle spent in IDLE.
- RUN:
  - If en=0: abort to IDLE, cnt <= 0, no tick. Abort has priority over wrap.
  - Else if cnt != prd: cnt <= cnt + 1.
  - Else (wrap): cnt <= 0 and tick <= 1 for exactly one cycle.
    - mode_q=0: stay in RUN.
    - mode_q=1: go to IDLE; busy falls on the same edge that raises tick.
- Period: prd+1 cycles. prd=0 in periodic mode gives tick every cycle.
- The first tick is registered prd+1 edges after busy rises.
- Shadow register:
  - load=1: shadow <= slice and pending <= 1.
  - At wrap or in IDLE: prd <= shadow and pending <= 0.
  - load on the wrap cycle: the new slice goes straight into prd and pending stays 0.
- start while in RUN: ignored. start with mode=0: ignored.
- The mode input has no effect while in RUN.
- Channels are fully independent; there is no cross-channel arbitration.
- Counter arithmetic is modulo 2^NBITS. Because cnt never exceeds prd, it does not overflow.
- Asserting reset mid-operation clears all state immediately; no tick is generated.

Optional Feature:
- PRESCALE_EN defined:
  - A shared free-running prescaler counts 0..PRESC_DIV-1 and asserts a strobe when it is at PRESC_DIV-1.
  - The prescaler resets to 0 and is independent of en.
  - Channel counting, wrap and tick happen only on strobe cycles, so the period is (prd+1)*PRESC_DIV cycles.
  - The en abort, start arming and shadow capture remain per-cycle.
  - tick stays exactly one clk cycle wide.
- PRESCALE_EN undefined:
  - No prescaler logic exists; the strobe is constantly 1 and PRESC_DIV is ignored.

Test Plan:
1. Hold rst=0 with random inputs, then release: tick=0, busy=0, pending=0, count=0; first load shows pending=1 one cycle later.
2. Periodic, NBITS=8: ch0 loaded with 3 while idle, en=1 -> busy=1; count sequence 0,1,2,3,0; tick one cycle wide every 4 cycles; 100 cycles give 25 ticks.
3. Shadow update: ch0 running with prd=3, load 9 at count=1 -> pending=1 until wrap; the current period still ends after 4 cycles; following periods are 10 cycles.
4. One-shot: ch1 with cmp=5, mode=1, start pulse -> busy high for 6 cycles; single tick as busy falls; a second start at count=2 is ignored; no further ticks.
5. Abort: ch0 with prd=7, drop en at count=2 -> next edge count=0, busy=0, no tick; re-raising en restarts from 0.
6. PRESCALE_EN with PRESC_DIV=4, cmp=1 -> tick every 8 cycles and one cycle wide; async reset mid-period clears count and tick on the same cycle and restores prd=0xFF.
